// File: rtl/uart_receiver.sv
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver (MSB first), oversampled by baud_tick.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_receiver #(
    parameter int OS_RATE = 16,
    parameter int CW      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic       uart_rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [CW-1:0] c_half_last = CW'(OS_RATE / 2 - 1);
    localparam logic [CW-1:0] c_full_last = CW'(OS_RATE - 1);

    state_t        state_q,      state_d;
    logic [CW-1:0] tick_cnt_q,   tick_cnt_d;
    logic [2:0]    bit_cnt_q,    bit_cnt_d;
    logic [7:0]    shift_q,      shift_d;
    logic [7:0]    data_q,       data_d;
    logic          data_valid_q, data_valid_d;
    logic          frame_err_q,  frame_err_d;
    logic          rx_prev_q,    rx_prev_d;
    logic          rx_meta_q;
    logic          rx_s_q;

    // Everything except the output pulses holds unless baud_tick is high.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        rx_prev_d    = rx_prev_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (baud_tick) begin
            rx_prev_d = rx_s_q;
            case (state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_s_q) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    if (tick_cnt_q == c_half_last) begin
                        state_d    = rx_s_q ? IDLE : DATA;
                        tick_cnt_d = '0;
                        bit_cnt_d  = 3'd0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt_q == c_full_last) begin
                        shift_d    = {shift_q[6:0], rx_s_q};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt_q == c_full_last) begin
                        state_d    = IDLE;
                        tick_cnt_d = '0;
                        if (rx_s_q) begin
                            data_d       = shift_q;
                            data_valid_d = 1'b1;
                        end else begin
                            frame_err_d  = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Synchronizer and rx_prev reset high so a released reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_prev_q    <= 1'b1;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            rx_prev_q    <= rx_prev_d;
            rx_meta_q    <= uart_rx;
            rx_s_q       <= rx_meta_q;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The parameters SHALL be as follows (name, default, meaning):
- OS_RATE, 16, baud ticks per bit; legal values are even and at least 4.
- CW, 4, tick counter width; must hold OS_RATE-1.

REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: clock; all logic on posedge.
- rst_n, in, 1: reset, asynchronous, active-low.
- baud_tick, in, 1: one-clk enable pulse at OS_RATE x bit rate.
- uart_rx, in, 1: asynchronous serial line; idle high.
- data, out, 8: last correctly framed byte.
- data_valid, out, 1: one-clk pulse when data is updated.
- frame_err, out, 1: one-clk pulse when the stop bit is sampled 0.
- busy, out, 1: high in any state other than IDLE.

Function
REQ-003 uart_rx SHALL pass through a 2-FF synchronizer whose flops reset to 1; all further logic uses the synchronized level rx_s only.
- rx_prev SHALL hold rx_s as sampled at the previous baud_tick, reset value 1.

REQ-004 Frame format SHALL be: 1 start bit (0), 8 data bits MSB first (data[7] first), 1 stop bit (1), no parity.
- This matches the team transmitter bit order.

REQ-005 The state machine SHALL have the states IDLE, START, DATA and STOP.
- State, tick counter and bit counter advance only in cycles where baud_tick=1.
- With baud_tick=0, every register except the synchronizer and the output pulses SHALL hold.

REQ-006 IDLE: on a tick with rx_prev=1 and rx_s=0 (falling edge), the block SHALL go to START with tick_cnt cleared to 0.
- A line held low continuously SHALL NOT re-trigger.

REQ-007 START: tick_cnt increments each tick; on the tick where tick_cnt reaches OS_RATE/2-1 (the start-bit midpoint):
- If rx_s=1 (false start), the block SHALL return to IDLE with no output.
- Otherwise it SHALL go to DATA with tick_cnt=0 and bit_cnt=0.

REQ-008 DATA: on the tick where tick_cnt reaches OS_RATE-1:
- The block SHALL sample rx_s into the shift register (shift left, new bit at LSB), clear tick_cnt and increment bit_cnt.
- After the 8th sample it SHALL go to STOP.

REQ-009 STOP: on the tick where tick_cnt reaches OS_RATE-1, the block SHALL sample rx_s and then return to IDLE in all cases.
- rx_s=1: data is loaded from the shift register and data_valid pulses.
- rx_s=0: frame_err pulses and data is unchanged.

REQ-010 Timing relative to the detecting tick (tick 0) SHALL be:
- Start bit sampled at tick OS_RATE/2.
- Data bit k (k=0..7, in transmission order) sampled at tick OS_RATE/2 + OS_RATE*(k+1).
- Stop bit sampled at tick OS_RATE/2 + 9*OS_RATE.

REQ-011 data_valid and frame_err SHALL be registered, assert in the clk cycle after the stop-sampling tick, last exactly one clk, and never assert together.

REQ-012 After a stop bit, a new start edge SHALL be detectable on the next tick in IDLE, so back-to-back frames with one stop bit are received without loss.
- After a frame error with the line still low, reception SHALL resume only once the line goes high and then falls again.

REQ-013 There SHALL be no flow control: a new data_valid overwrites data, and the consumer must capture it on the pulse.

REQ-014 busy SHALL be combinational from the state: high in START, DATA and STOP.

Reset
REQ-015 When rst_n=0, the block SHALL immediately set:
- state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0.
- data=8'h00, data_valid=0, frame_err=0.
- Synchronizer flops and rx_prev = 1.

REQ-016 Reset asserted mid-frame SHALL abort the frame with no output pulse.
- After release, a partial frame still on the line SHALL NOT be reported unless it presents a new falling edge.

Verification
REQ-017 The bench SHALL drive 0xA5 with OS_RATE=16 ticks per bit -> exactly one data_valid pulse, data=8'hA5, frame_err never high, busy low afterwards.

REQ-018 The bench SHALL drive a 4-tick low glitch from idle -> busy goes high then returns to IDLE at start midpoint; no data_valid or frame_err pulse; data unchanged.

REQ-019 The bench SHALL receive 0xA5, then drive 0x3C with its stop bit forced to 0 -> one frame_err pulse, no data_valid, data stays 8'hA5.

REQ-020 The bench SHALL send 0x00 then 0xFF back-to-back with a single stop bit between them -> two data_valid pulses, with data 8'h00 then 8'hFF.

REQ-021 The bench SHALL assert rst_n low during data bit 3 of a frame, then release it and send 0x5A -> data=8'h00 immediately after reset, no pulse for the aborted frame, then data=8'h5A with one data_valid pulse.

REQ-022 The bench SHALL hold baud_tick=0 for 100 clk mid-frame, then resume ticks -> state and counters frozen during the gap, and the byte is still received correctly.
